// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment display controller: latches a packed hex word and
// scans it across N_DIGITS common-anode digits with a dark interval at every switch.
module seg_scan_display #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   BCD_Data,
  input  logic [N_DIGITS-1:0]     DP_Data,
  input  logic                    Blank_LZ,
  input  logic                    Display_WE,
  output logic [N_DIGITS-1:0]     Anode_Control,
  output logic [6:0]              Cathode_Control,
  output logic                    DP_Control,
  output logic [4*N_DIGITS-1:0]   Display_Data
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_DEAD  = PRE_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] data_r;
  logic [N_DIGITS-1:0]   dp_r;
  logic                  blz_r;
  logic [PRE_W-1:0]      pre_r;
  logic [IDX_W-1:0]      idx_r;
  logic [N_DIGITS-1:0]   anode_r;
  logic [6:0]            cath_r;
  logic                  dp_out_r;

  logic [N_DIGITS-1:0]   blank_s;
  logic                  nz_acc_s;
  logic [N_DIGITS-1:0]   anode_sel_s;
  logic [3:0]            nib_s;
  logic                  dp_sel_s;
  logic                  blank_sel_s;
  logic                  dark_s;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Shadow register for the display word, decimal points and blanking mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= '0;
      dp_r   <= '0;
      blz_r  <= 1'b0;
    end else if (Display_WE) begin
      data_r <= BCD_Data;
      dp_r   <= DP_Data;
      blz_r  <= Blank_LZ;
    end else begin
      data_r <= data_r;
      dp_r   <= dp_r;
      blz_r  <= blz_r;
    end
  end

  // Slot prescaler and digit index; writes never disturb the scan position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= '0;
      idx_r <= '0;
    end else if (pre_r == PRE_LAST) begin
      pre_r <= '0;
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      pre_r <= pre_r + PRE_W'(1);
      idx_r <= idx_r;
    end
  end

  // Leading-zero mask: scanning from the top, a digit stays blank until a
  // nonzero nibble or a lit decimal point is seen at or above it.
  always_comb begin
    blank_s  = '0;
    nz_acc_s = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nz_acc_s   = nz_acc_s | (|data_r[4*i +: 4]) | dp_r[i];
      blank_s[i] = blz_r & ~nz_acc_s & (i != 0);
    end
  end

  // Select the current digit's nibble, decimal point and blank flag.
  always_comb begin
    nib_s       = 4'h0;
    dp_sel_s    = 1'b0;
    blank_sel_s = 1'b0;
    anode_sel_s = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        nib_s          = data_r[4*i +: 4];
        dp_sel_s       = dp_r[i];
        blank_sel_s    = blank_s[i];
        anode_sel_s[i] = 1'b0;
      end else begin
        anode_sel_s[i] = 1'b1;
      end
    end
    dark_s = (pre_r < PRE_DEAD) | blank_sel_s;
  end

  // Pin register, one cycle behind the scan counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_r  <= '1;
      cath_r   <= 7'h7F;
      dp_out_r <= 1'b1;
    end else if (dark_s) begin
      anode_r  <= '1;
      cath_r   <= 7'h7F;
      dp_out_r <= 1'b1;
    end else begin
      anode_r  <= anode_sel_s;
      cath_r   <= hex_to_seg(nib_s);
      dp_out_r <= ~dp_sel_s;
    end
  end

  assign Anode_Control   = anode_r;
  assign Cathode_Control = cath_r;
  assign DP_Control      = dp_out_r;
  assign Display_Data    = data_r;

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display controller: the successor to the current fixed 8-digit display path. Latches a packed BCD/hex word on a write strobe, time-multiplexes it across `N_DIGITS` common-anode digits, and adds per-digit decimal points, optional leading-zero blanking, and an anti-ghosting dead interval at every digit switch. It sits between the processor's memory-mapped display register write and the board's anode/cathode pins.

## Interface
- `N_DIGITS`, 8: number of digits scanned; range 1..16.
- `REFRESH_DIV`, 100000: clock cycles per digit slot; must be ≥ 2.
- `DEAD_CYCLES`, 2: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ DEAD_CYCLES < REFRESH_DIV.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `BCD_Data`  in  4*N_DIGITS  packed nibbles; digit 0 is at [3:0].
- `DP_Data`  in  N_DIGITS  decimal-point enable per digit (1 = lit).
- `Blank_LZ`  in  1  leading-zero blanking enable.
- `Display_WE`  in  1  latch BCD_Data, DP_Data and Blank_LZ.
- `Anode_Control`  out  N_DIGITS  active-low digit enables.
- `Cathode_Control`  out  7  active-low segments {g,f,e,d,c,b,a}.
- `DP_Control`  out  1  active-low decimal point.
- `Display_Data`  out  4*N_DIGITS  latched data word (readback).

## Operation
- Shadow register: on a `clk` edge with `Display_WE`=1, capture `BCD_Data`, `DP_Data` and `Blank_LZ`. Otherwise hold. `Display_Data` is the latched word.
- Prescaler `pre` counts 0..REFRESH_DIV-1 and wraps to 0. Digit index `idx` counts 0..N_DIGITS-1. `idx` advances only on the cycle where `pre`=REFRESH_DIV-1, and wraps from N_DIGITS-1 to 0.
- Blanking: digit i (i>0) is blanked when latched Blank_LZ=1 and every nibble and DP bit at positions ≥ i is zero. Digit 0 is never blanked. With Blank_LZ=0, no digit is blanked.
- Output register, updated every cycle from the current `pre`/`idx`:
  - If `pre` < DEAD_CYCLES, or digit `idx` is blanked: Anode_Control all 1s, Cathode_Control = 7'h7F, DP_Control = 1.
  - Otherwise: Anode_Control has bit `idx` = 0 and all other bits 1. Cathode_Control = decode(nibble idx). DP_Control = ~DP[idx].
- Hex decode (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- A write in mid-slot takes effect from the next output-register update. The scan position is not disturbed.

## Timing
- Reset (rst=0, asynchronous and immediate): shadow data/DP/Blank_LZ = 0, `pre` = 0, `idx` = 0, Anode_Control = all 1s, Cathode_Control = 7'h7F, DP_Control = 1, Display_Data = 0.
- After rst is released, the first output update occurs on the first `clk` edge.
- Display_WE latency: Display_Data is valid 1 cycle after the write edge. Pins reflect the new data 2 edges after the write edge (shadow register, then output register), provided the current digit is in its active window.
- Outputs lag (`pre`, `idx`) by exactly 1 cycle.
- Slot length is REFRESH_DIV cycles, of which the first DEAD_CYCLES are dark. Frame length is N_DIGITS*REFRESH_DIV cycles.
- Reset asserted mid-slot or mid-write: all state is cleared at once. A Display_WE that coincides with reset is lost.
- N_DIGITS=1: `idx` stays 0 permanently. The dead interval still applies every REFRESH_DIV cycles.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.

- **Reset:** pulse rst low mid-slot with no clock edge → Anode_Control=4'hF, Cathode_Control=7'h7F, DP_Control=1 and Display_Data=0 immediately.
- **Write and scan:** write 16'h1234 with Blank_LZ=0 and DP_Data=0.
  - Display_Data=16'h1234 one cycle later.
  - Per 16-cycle frame, each slot shows 1 dark cycle (4'hF), then 3 cycles per digit: 4'b1110/0011001, 4'b1101/0110000, 4'b1011/0100100, 4'b0111/1111001.
- **No-write hold:** toggle BCD_Data every cycle with Display_WE=0 → Display_Data and the segment patterns stay unchanged across 2 frames.
- **Leading-zero blanking:** write 16'h0050 with Blank_LZ=1.
  - Anode bits 3 and 2 never go low. Digit 1 shows 0010010; digit 0 shows 1000000.
  - Then write 16'h0000: only digit 0 is ever lit, showing 1000000.
- **Decimal point stops blanking:** write 16'h0005 with DP_Data=4'b0100 and Blank_LZ=1.
  - Digit 3 stays blank. Digit 2 shows 1000000 with DP_Control=0. Digit 1 shows 1000000 with DP_Control=1. Digit 0 shows 0010010.
- **Wrap and dead time:** across 3 frames, anode-low periods recur every 16 cycles with exactly 1 all-high cycle between consecutive digits, and the index wraps from 3 to 0.
